// File: rtl/note_sequencer.sv
// PS/2 scancode parser, held-key tracker and square-wave tone generator for a single-voice synth.
// Define OCTAVE_SHIFT_EN to add Z/X octave shifting (-1..+2) of the sounding note.
module note_sequencer #(
  parameter int HP_WIDTH     = 21,
  parameter bit FALLBACK_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          data,
  input  logic                data_valid,
  output logic [HP_WIDTH-1:0] half_period,
  output logic                note_on,
  output logic [3:0]          note_idx,
  output logic [11:0]         held_mask,
  output logic                speaker
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [HP_WIDTH-1:0] HP_ONE = HP_WIDTH'(1);

  state_t              state_reg, state_next;
  logic [11:0]         held_reg, held_next;
  logic [3:0]          idx_reg, idx_next;
  logic                on_reg, on_next;
  logic [HP_WIDTH-1:0] hp_reg, hp_next;
  logic [HP_WIDTH-1:0] cnt_reg;
  logic                spk_reg;
  logic                key_hit;
  logic [3:0]          key_idx;
  logic [11:0]         remain;
  logic                low_hit;
  logic [3:0]          low_idx;
  logic                restart;
`ifdef OCTAVE_SHIFT_EN
  logic signed [2:0]   oct_reg, oct_next;
`endif

  function automatic logic [HP_WIDTH-1:0] base_of(input logic [3:0] i);
    case (i)
      4'd0:    base_of = HP_WIDTH'(95555);
      4'd1:    base_of = HP_WIDTH'(90192);
      4'd2:    base_of = HP_WIDTH'(85130);
      4'd3:    base_of = HP_WIDTH'(80352);
      4'd4:    base_of = HP_WIDTH'(75842);
      4'd5:    base_of = HP_WIDTH'(71585);
      4'd6:    base_of = HP_WIDTH'(67568);
      4'd7:    base_of = HP_WIDTH'(63775);
      4'd8:    base_of = HP_WIDTH'(60196);
      4'd9:    base_of = HP_WIDTH'(56817);
      4'd10:   base_of = HP_WIDTH'(53628);
      default: base_of = HP_WIDTH'(50618);
    endcase
  endfunction

  always_comb begin : key_decode
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (data)
      8'h15:   key_idx = 4'd0;
      8'h1D:   key_idx = 4'd1;
      8'h24:   key_idx = 4'd2;
      8'h2D:   key_idx = 4'd3;
      8'h2C:   key_idx = 4'd4;
      8'h35:   key_idx = 4'd5;
      8'h3C:   key_idx = 4'd6;
      8'h43:   key_idx = 4'd7;
      8'h44:   key_idx = 4'd8;
      8'h4D:   key_idx = 4'd9;
      8'h54:   key_idx = 4'd10;
      8'h5B:   key_idx = 4'd11;
      default: key_hit = 1'b0;
    endcase
  end

  // Lowest-index key still held if the decoded key were released.
  always_comb begin : fallback_pick
    remain  = held_reg & ~(12'd1 << key_idx);
    low_hit = 1'b0;
    low_idx = 4'd0;
    for (int k = 11; k >= 0; k--) begin
      if (remain[k]) begin
        low_hit = 1'b1;
        low_idx = 4'(k);
      end
    end
  end

  always_comb begin : parser
    state_next = state_reg;
    held_next  = held_reg;
    idx_next   = idx_reg;
    on_next    = on_reg;
`ifdef OCTAVE_SHIFT_EN
    oct_next   = oct_reg;
`endif
    if (data_valid) begin
      case (state_reg)
        IDLE: begin
          if (data == 8'hF0) begin
            state_next = BRK;
          end else if (data == 8'hE0) begin
            state_next = EXT;
          end else if (key_hit) begin
            held_next[key_idx] = 1'b1;
            idx_next           = key_idx;
            on_next            = 1'b1;
`ifdef OCTAVE_SHIFT_EN
          end else if (data == 8'h1A) begin
            if (oct_reg != -3'sd1) oct_next = oct_reg - 3'sd1;
          end else if (data == 8'h22) begin
            if (oct_reg != 3'sd2) oct_next = oct_reg + 3'sd1;
`endif
          end
        end
        BRK: begin
          state_next = IDLE;
          if (key_hit && held_reg[key_idx]) begin
            held_next = remain;
            if (on_reg && idx_reg == key_idx) begin
              if (FALLBACK_LOW && low_hit) begin
                idx_next = low_idx;
              end else begin
                on_next  = 1'b0;
                idx_next = 4'd0;
              end
            end
          end
        end
        EXT:     state_next = (data == 8'hF0) ? EXT_BRK : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin : period_select
    hp_next = '0;
    if (on_next) begin
`ifdef OCTAVE_SHIFT_EN
      case (oct_next)
        -3'sd1:  hp_next = base_of(idx_next) << 1;
        3'sd1:   hp_next = base_of(idx_next) >> 1;
        3'sd2:   hp_next = base_of(idx_next) >> 2;
        default: hp_next = base_of(idx_next);
      endcase
`else
      hp_next = base_of(idx_next);
`endif
    end
  end

  assign restart = (hp_next != hp_reg) || (idx_next != idx_reg) || (on_next != on_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      held_reg  <= '0;
      idx_reg   <= '0;
      on_reg    <= 1'b0;
      hp_reg    <= '0;
`ifdef OCTAVE_SHIFT_EN
      oct_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
      idx_reg   <= idx_next;
      on_reg    <= on_next;
      hp_reg    <= hp_next;
`ifdef OCTAVE_SHIFT_EN
      oct_reg   <= oct_next;
`endif
    end
  end

  // A note change restarts the period but keeps the speaker level to avoid a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      spk_reg <= 1'b0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (!on_reg) begin
      cnt_reg <= '0;
      spk_reg <= 1'b0;
    end else if (cnt_reg == hp_reg - HP_ONE) begin
      cnt_reg <= '0;
      spk_reg <= ~spk_reg;
    end else begin
      cnt_reg <= cnt_reg + HP_ONE;
    end
  end

  assign half_period = hp_reg;
  assign note_on     = on_reg;
  assign note_idx    = idx_reg;
  assign held_mask   = held_reg;
  assign speaker     = spk_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: each byte pushes the expected post-byte state, a monitor compares.
module tb_note_sequencer;
  localparam int HPW = 21;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     data = 8'h00;
  logic           data_valid = 1'b0;
  logic [HPW-1:0] half_period;
  logic           note_on;
  logic [3:0]     note_idx;
  logic [11:0]    held_mask;
  logic           speaker;

  typedef struct packed {
    logic [11:0]    mask;
    logic [3:0]     idx;
    logic           on;
    logic [HPW-1:0] hp;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic dv_seen = 1'b0;

  always #10 clk = ~clk;

  note_sequencer #(.HP_WIDTH(HPW), .FALLBACK_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .half_period(half_period), .note_on(note_on), .note_idx(note_idx),
    .held_mask(held_mask), .speaker(speaker)
  );

  always @(posedge clk) dv_seen <= data_valid && !rst;

  // Monitor: outputs are presented the cycle after each accepted strobe.
  always @(negedge clk) begin
    if (dv_seen) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL mon_underflow: got output with no expectation queued");
      end else begin
        mon_e = expq.pop_front();
        if (held_mask !== mon_e.mask || note_idx !== mon_e.idx ||
            note_on !== mon_e.on || half_period !== mon_e.hp) begin
          bad++;
          $display("FAIL mon: got mask=%03h idx=%0d on=%0b hp=%0d want mask=%03h idx=%0d on=%0b hp=%0d",
                   held_mask, note_idx, note_on, half_period, mon_e.mask, mon_e.idx, mon_e.on, mon_e.hp);
        end else begin
          $display("ok  byte result mask=%03h idx=%0d on=%0b hp=%0d", held_mask, note_idx, note_on, half_period);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end else begin
      $display("ok  %s = %0d", name, act);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic [11:0] m, input logic [3:0] i,
                      input logic on, input logic [HPW-1:0] hp);
    expq.push_back({m, i, on, hp});
    @(posedge clk);
    #1 data = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held", 32'(held_mask), 0);
    chk("rst_on", 32'(note_on), 0);
    chk("rst_hp", 32'(half_period), 0);
    chk("rst_spk", 32'(speaker), 0);
    rst = 1'b0;

    send(8'h15, 12'h001, 4'd0, 1'b1, 21'd95555);   // press Q
    send(8'h24, 12'h005, 4'd2, 1'b1, 21'd85130);   // press E
    send(8'h24, 12'h005, 4'd2, 1'b1, 21'd85130);   // typematic E
    send(8'hF0, 12'h005, 4'd2, 1'b1, 21'd85130);
    send(8'h24, 12'h001, 4'd0, 1'b1, 21'd95555);   // release E -> Q
    send(8'hF0, 12'h001, 4'd0, 1'b1, 21'd95555);
    send(8'h15, 12'h000, 4'd0, 1'b0, 21'd0);       // release Q -> mute
    send(8'hF0, 12'h000, 4'd0, 1'b0, 21'd0);
    send(8'h15, 12'h000, 4'd0, 1'b0, 21'd0);       // release Q while muted
    send(8'hF0, 12'h000, 4'd0, 1'b0, 21'd0);
    send(8'h4D, 12'h000, 4'd0, 1'b0, 21'd0);       // release unheld P
    send(8'h1C, 12'h000, 4'd0, 1'b0, 21'd0);       // unmapped A
    send(8'h15, 12'h001, 4'd0, 1'b1, 21'd95555);   // press Q
    send(8'hE0, 12'h001, 4'd0, 1'b1, 21'd95555);   // extended break of Q: ignored
    send(8'hF0, 12'h001, 4'd0, 1'b1, 21'd95555);
    send(8'h15, 12'h001, 4'd0, 1'b1, 21'd95555);
    send(8'h1D, 12'h003, 4'd1, 1'b1, 21'd90192);   // press W
    send(8'hF0, 12'h003, 4'd1, 1'b1, 21'd90192);
    send(8'h1D, 12'h001, 4'd0, 1'b1, 21'd95555);   // release W -> Q
    send(8'h5B, 12'h801, 4'd11, 1'b1, 21'd50618);  // press ]

    // Counter restarted at the ] edge; speaker rises exactly 50618 clocks later.
    repeat (50617) @(posedge clk);
    #1 chk("spk_before_toggle", 32'(speaker), 0);
    @(posedge clk);
    #1 chk("spk_at_toggle", 32'(speaker), 1);

    #3 rst = 1'b1;
    #1;
    chk("arst_held", 32'(held_mask), 0);
    chk("arst_on", 32'(note_on), 0);
    chk("arst_idx", 32'(note_idx), 0);
    chk("arst_hp", 32'(half_period), 0);
    chk("arst_spk", 32'(speaker), 0);
    @(posedge clk);
    #1 data = 8'h15;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_dv_ignored", 32'(held_mask), 0);

    send(8'hF0, 12'h000, 4'd0, 1'b0, 21'd0);       // parsed from IDLE after reset
    send(8'h2C, 12'h000, 4'd0, 1'b0, 21'd0);       // release of unheld T
    send(8'h2C, 12'h010, 4'd4, 1'b1, 21'd75842);   // press T
    send(8'h35, 12'h030, 4'd5, 1'b1, 21'd71585);   // press Y
    send(8'h43, 12'h0B0, 4'd7, 1'b1, 21'd63775);   // press I
    send(8'h54, 12'h4B0, 4'd10, 1'b1, 21'd53628);  // press [
    send(8'hF0, 12'h4B0, 4'd10, 1'b1, 21'd53628);
    send(8'h54, 12'h0B0, 4'd4, 1'b1, 21'd75842);   // release [ -> lowest T
    send(8'hF0, 12'h0B0, 4'd4, 1'b1, 21'd75842);
    send(8'h2C, 12'h0A0, 4'd5, 1'b1, 21'd71585);   // release T -> Y
    send(8'hF0, 12'h0A0, 4'd5, 1'b1, 21'd71585);
    send(8'h35, 12'h080, 4'd7, 1'b1, 21'd63775);   // release Y -> I
    send(8'hF0, 12'h080, 4'd7, 1'b1, 21'd63775);
    send(8'h43, 12'h000, 4'd0, 1'b0, 21'd0);       // release I -> mute
    repeat (2) @(posedge clk);
    #1 chk("muted_spk", 32'(speaker), 0);

    send(8'h5B, 12'h800, 4'd11, 1'b1, 21'd50618);  // press ]
`ifdef OCTAVE_SHIFT_EN
    send(8'h22, 12'h800, 4'd11, 1'b1, 21'd25309);
    send(8'h22, 12'h800, 4'd11, 1'b1, 21'd12654);
    send(8'h22, 12'h800, 4'd11, 1'b1, 21'd12654);  // saturated at +2
    send(8'h1A, 12'h800, 4'd11, 1'b1, 21'd25309);
    send(8'h1A, 12'h800, 4'd11, 1'b1, 21'd50618);
    send(8'h1A, 12'h800, 4'd11, 1'b1, 21'd101236);
    send(8'h1A, 12'h800, 4'd11, 1'b1, 21'd101236); // saturated at -1
    send(8'hF0, 12'h800, 4'd11, 1'b1, 21'd101236);
    send(8'h22, 12'h800, 4'd11, 1'b1, 21'd101236); // X break consumed
`else
    send(8'h22, 12'h800, 4'd11, 1'b1, 21'd50618);  // X unmapped
    send(8'h1A, 12'h800, 4'd11, 1'b1, 21'd50618);  // Z unmapped
`endif

    repeat (3) @(posedge clk);
    #1 chk("queue_empty", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
